// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage controller: opcodes, FSM states,
// access sizes and the memory-op decoder.
package mem_ctrl_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

  typedef struct packed {
    logic  is_mem;
    logic  is_load;
    logic  sign_ext;
    size_t size;
  } mem_op_t;

  // Sub-word opcodes only count as memory ops when subword decoding is enabled.
  function automatic mem_op_t decode_mem(input logic [5:0] op, input logic subword);
    mem_op_t d;
    d = '{is_mem: 1'b0, is_load: 1'b0, sign_ext: 1'b0, size: WORD};
    case (op)
      OP_LW:  begin d.is_mem = 1'b1; d.is_load = 1'b1; end
      OP_SW:  d.is_mem = 1'b1;
      OP_LB:  begin d.is_mem = subword; d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = BYTE; end
      OP_LBU: begin d.is_mem = subword; d.is_load = 1'b1; d.size = BYTE; end
      OP_LH:  begin d.is_mem = subword; d.is_load = 1'b1; d.sign_ext = 1'b1; d.size = HALF; end
      OP_LHU: begin d.is_mem = subword; d.is_load = 1'b1; d.size = HALF; end
      OP_SB:  begin d.is_mem = subword; d.size = BYTE; end
      OP_SH:  begin d.is_mem = subword; d.size = HALF; end
      default: ;
    endcase
    return d;
  endfunction

  // Word needs both low bits clear, half needs bit 0 clear, byte always fits.
  function automatic logic is_aligned(input size_t size, input logic [1:0] lo);
    logic ok;
    case (size)
      WORD:    ok = (lo == 2'b00);
      HALF:    ok = ~lo[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a read word and extends it.
module load_align
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  size_t       size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, then sign or zero extension by access size.
  always_comb begin
    case (addr)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      BYTE:    result = {{24{sign_ext & byte_v[7]}}, byte_v};
      HALF:    result = {{16{sign_ext & half_v[15]}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: decodes the instruction, checks alignment, runs one
// memory access per op with a bounded wait, and returns aligned load data.
//
// Memory handshake: mem_req is high for the whole ACCESS state with
// mem_we/mem_be/mem_addr/mem_wdata held stable; the access completes in the
// first cycle mem_ack is sampled high while mem_req is high (mem_rdata valid
// in that cycle). mem_ack outside ACCESS is ignored.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int SUBWORD_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [31:0]       Inst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       RdData,
  output logic              rd_valid,
  output logic              Stall,
  output logic              AddrErr,
  output logic              Timeout,
  output logic              Jump,
  output logic              Branch
);

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  mem_op_t     dec;
  logic        aligned, start, misalign;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  size_t       lat_size;
  logic        lat_sign, lat_load;
  logic [1:0]  lat_lo;
  logic [31:0] load_res;
  logic        unused_inst;

  assign unused_inst = ^Inst[25:0];

  // Control-flow decode is independent of the FSM and of inst_valid.
  assign Jump   = (Inst[31:26] == OP_J)   | (Inst[31:26] == OP_JAL);
  assign Branch = (Inst[31:26] == OP_BEQ) | (Inst[31:26] == OP_BNE);

  // Memory-op decode and alignment check for the incoming instruction.
  always_comb begin
    dec      = decode_mem(Inst[31:26], SUBWORD_EN != 0);
    aligned  = is_aligned(dec.size, Addr[1:0]);
    start    = (state == IDLE) & inst_valid & dec.is_mem & aligned;
    misalign = (state == IDLE) & inst_valid & dec.is_mem & ~aligned;
  end

  assign Stall = start | ((state == ACCESS) & ~mem_ack);

  // Byte enables and lane-replicated write data for the access size.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = WrData;
    case (dec.size)
      BYTE: begin
        be_next    = 4'b0001 << Addr[1:0];
        wdata_next = {4{WrData[7:0]}};
      end
      HALF: begin
        be_next    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{WrData[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata    (mem_rdata),
    .addr     (lat_lo),
    .size     (lat_size),
    .sign_ext (lat_sign),
    .result   (load_res)
  );

  // Access FSM with registered request, result and pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      RdData    <= 32'd0;
      rd_valid  <= 1'b0;
      AddrErr   <= 1'b0;
      Timeout   <= 1'b0;
      lat_size  <= WORD;
      lat_sign  <= 1'b0;
      lat_load  <= 1'b0;
      lat_lo    <= 2'b00;
    end else begin
      rd_valid <= 1'b0;
      AddrErr  <= 1'b0;
      Timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ACCESS;
            wait_cnt  <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= ~dec.is_load;
            mem_be    <= be_next;
            mem_addr  <= {Addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata_next;
            lat_size  <= dec.size;
            lat_sign  <= dec.sign_ext;
            lat_load  <= dec.is_load;
            lat_lo    <= Addr[1:0];
          end else if (misalign) begin
            AddrErr <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (lat_load) begin
              RdData   <= load_res;
              rd_valid <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LIMIT) begin
            state   <= ERR;
            mem_req <= 1'b0;
            Timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with an event scoreboard.
module tb_mem_stage_ctrl;
  import mem_ctrl_pkg::*;

  localparam int W = 72;
  localparam logic [2:0] K_REQ = 3'd1;
  localparam logic [2:0] K_RD  = 3'd2;
  localparam logic [2:0] K_AE  = 3'd3;
  localparam logic [2:0] K_TO  = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] Inst = 32'd0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] WrData = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_req, mem_we, rd_valid, Stall, AddrErr, Timeout, Jump, Branch;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, RdData;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic prev_req = 1'b0;

  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4), .SUBWORD_EN(1)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .Inst(Inst),
    .Addr(Addr), .WrData(WrData), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .RdData(RdData),
    .rd_valid(rd_valid), .Stall(Stall), .AddrErr(AddrErr),
    .Timeout(Timeout), .Jump(Jump), .Branch(Branch)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [2:0] k, input logic we,
                                      input logic [3:0] be, input logic [31:0] a,
                                      input logic [31:0] d);
    return {k, we, be, a, d};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic observe(input logic [W-1:0] ev);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=%h expected=none", ev);
    end else begin
      check("event", ev, exp_q.pop_front());
    end
  endtask

  // monitor: turns DUT outputs into events and scores them against exp_q
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req)
        observe(mk(K_REQ, mem_we, mem_we ? mem_be : 4'b0000, mem_addr,
                   mem_we ? mem_wdata : 32'd0));
      if (rd_valid) observe(mk(K_RD, 1'b0, 4'b0000, 32'd0, RdData));
      if (AddrErr)  observe(mk(K_AE, 1'b0, 4'b0000, 32'd0, 32'd0));
      if (Timeout)  observe(mk(K_TO, 1'b0, 4'b0000, 32'd0, 32'd0));
      prev_req = mem_req;
    end
  end

  // driver: issue one instruction, answer with mem_ack on ACCESS cycle ack_on (0 = never)
  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_on, input logic [31:0] rd,
                        input int exp_stall, input int exp_acc);
    int stall_n;
    int acc_n;
    stall_n = 0;
    acc_n = 0;
    Inst = {op, 26'd0};
    Addr = a;
    WrData = wd;
    inst_valid = 1'b1;
    @(negedge clk);
    if (Stall) stall_n++;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    Inst = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      if (!mem_req) break;
      acc_n++;
      if (op == OP_LW && acc_n == 1) check({name, "_be"}, mem_be, 4'b1111);
      mem_ack = (k == ack_on);
      mem_rdata = rd;
      @(negedge clk);
      if (Stall) stall_n++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    check({name, "_req_done"}, mem_req, 1'b0);
    check({name, "_stall_cycles"}, stall_n, exp_stall);
    check({name, "_access_cycles"}, acc_n, exp_acc);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_we_rdv", {mem_req, mem_we, rd_valid}, 3'b000);
    check("rst_pulses", {AddrErr, Timeout, Stall}, 3'b000);
    check("rst_be", mem_be, 4'b0000);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rddata", RdData, 32'd0);
    check("rst_state", dut.state, IDLE);
    reset = 1'b0;
    @(posedge clk); #1;

    // combinational control-flow decode, no inst_valid
    Inst = {OP_J, 26'd5};   #1; check("dec_j",   {Jump, Branch}, 2'b10);
    Inst = {OP_JAL, 26'd0}; #1; check("dec_jal", {Jump, Branch}, 2'b10);
    Inst = {OP_BEQ, 26'd0}; #1; check("dec_beq", {Jump, Branch}, 2'b01);
    Inst = {OP_BNE, 26'd0}; #1; check("dec_bne", {Jump, Branch}, 2'b01);
    Inst = {OP_LW, 26'd0};  #1; check("dec_lw",  {Jump, Branch}, 2'b00);
    Inst = 32'd0;
    @(posedge clk); #1;

    // loads
    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h100, 32'd0));
    exp_q.push_back(mk(K_RD, 1'b0, 4'b0000, 32'd0, 32'hDEADBEEF));
    run_op("lw_100", OP_LW, 32'h100, 32'd0, 3, 32'hDEADBEEF, 3, 3);

    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h100, 32'd0));
    exp_q.push_back(mk(K_RD, 1'b0, 4'b0000, 32'd0, 32'hFFFFFF80));
    run_op("lb_103", OP_LB, 32'h103, 32'd0, 1, 32'h80112233, 1, 1);

    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h100, 32'd0));
    exp_q.push_back(mk(K_RD, 1'b0, 4'b0000, 32'd0, 32'h00000080));
    run_op("lbu_103", OP_LBU, 32'h103, 32'd0, 1, 32'h80112233, 1, 1);

    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h100, 32'd0));
    exp_q.push_back(mk(K_RD, 1'b0, 4'b0000, 32'd0, 32'h00008011));
    run_op("lhu_102", OP_LHU, 32'h102, 32'd0, 1, 32'h80112233, 1, 1);

    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h100, 32'd0));
    exp_q.push_back(mk(K_RD, 1'b0, 4'b0000, 32'd0, 32'hFFFF8011));
    run_op("lh_102", OP_LH, 32'h102, 32'd0, 2, 32'h80112233, 2, 2);

    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h100, 32'd0));
    exp_q.push_back(mk(K_RD, 1'b0, 4'b0000, 32'd0, 32'h00000022));
    run_op("lb_101", OP_LB, 32'h101, 32'd0, 1, 32'h80112233, 1, 1);

    // stores
    exp_q.push_back(mk(K_REQ, 1'b1, 4'b1100, 32'h104, 32'hABCDABCD));
    run_op("sh_106", OP_SH, 32'h106, 32'h0000ABCD, 2, 32'd0, 2, 2);

    exp_q.push_back(mk(K_REQ, 1'b1, 4'b0010, 32'h100, 32'h78787878));
    run_op("sb_101", OP_SB, 32'h101, 32'h12345678, 1, 32'd0, 1, 1);

    exp_q.push_back(mk(K_REQ, 1'b1, 4'b1111, 32'h200, 32'hCAFEF00D));
    run_op("sw_200", OP_SW, 32'h200, 32'hCAFEF00D, 1, 32'd0, 1, 1);

    // misaligned and non-memory ops
    exp_q.push_back(mk(K_AE, 1'b0, 4'b0000, 32'd0, 32'd0));
    run_op("lw_102", OP_LW, 32'h102, 32'd0, 1, 32'd0, 0, 0);

    exp_q.push_back(mk(K_AE, 1'b0, 4'b0000, 32'd0, 32'd0));
    run_op("sh_101", OP_SH, 32'h101, 32'h1111, 1, 32'd0, 0, 0);

    run_op("nop", 6'b000000, 32'h100, 32'd0, 1, 32'd0, 0, 0);

    // timeout, then ack exactly on the limit cycle
    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h300, 32'd0));
    exp_q.push_back(mk(K_TO, 1'b0, 4'b0000, 32'd0, 32'd0));
    run_op("lw_timeout", OP_LW, 32'h300, 32'd0, 0, 32'd0, 5, 4);

    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h304, 32'd0));
    exp_q.push_back(mk(K_RD, 1'b0, 4'b0000, 32'd0, 32'h01234567));
    run_op("lw_ack_at_limit", OP_LW, 32'h304, 32'd0, 4, 32'h01234567, 4, 4);

    // reset in the second ACCESS cycle
    exp_q.push_back(mk(K_REQ, 1'b0, 4'b0000, 32'h400, 32'd0));
    Inst = {OP_LW, 26'd0};
    Addr = 32'h400;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    Inst = 32'd0;
    @(posedge clk); #1;
    check("rst_mid_req_before", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_req_drop", mem_req, 1'b0);
    check("rst_mid_stall", Stall, 1'b0);
    check("rst_mid_state", dut.state, IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_rdv", rd_valid, 1'b0);
    check("late_ack_rddata", RdData, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
